ad7903_acq_ctrl: RTL and testbench

Acquisition sequencer for one dual-channel AD7903 front end. It paces conversions at a fixed sample rate, drives the shared CNV pin, then launches two SPI_AD7903 master instances (channel A and channel B) with a common start strobe. It waits for both transfers to complete, latches both 16-bit results and presents them as one valid-tagged sample pair to downstream logic. It sits between the board-level ADC pins/SPI masters and the data-processing chain, and owns error reporting for the acquisition path.

---
 rtl/ad7903_pkg.sv | 21 ++
 rtl/ad7903_rate_tick.sv | 46 ++++
 rtl/ad7903_acq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ad7903_acq_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad7903_pkg.sv
// Shared definitions for the AD7903 acquisition path: sequencer state codes,
// SPI master state encodings and the default sample width.
`timescale 1ns/1ps
package ad7903_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  // SPI_AD7903 master state encodings as seen on its state output.
  localparam logic [2:0] SPI_ST_IDLE = 3'd0;
  localparam logic [2:0] SPI_ST_DONE = 3'd4;

  // Acquisition sequencer states (plain constants so older tools accept them).
  typedef logic [2:0] acq_state_t;
  localparam acq_state_t ST_IDLE      = 3'd0;
  localparam acq_state_t ST_CNV_HI    = 3'd1;
  localparam acq_state_t ST_CONV_WAIT = 3'd2;
  localparam acq_state_t ST_SPI_START = 3'd3;
  localparam acq_state_t ST_SPI_WAIT  = 3'd4;
  localparam acq_state_t ST_LATCH     = 3'd5;

endpackage

// File: rtl/ad7903_rate_tick.sv
// Sample-rate pacer: counts 0..PERIOD_CYCLES-1 while enabled and emits a
// registered one-cycle tick at terminal count. Held at zero while disabled,
// so the first tick lands PERIOD_CYCLES cycles after enable rises.
`timescale 1ns/1ps
module ad7903_rate_tick #(
  parameter int PERIOD_CYCLES = 2000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(PERIOD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count and tick; wraps to zero on the tick cycle.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (en_i) begin
      if (cnt_q == CNT_LAST) begin
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/ad7903_acq_ctrl.sv
// Acquisition sequencer for a dual-channel AD7903 front end: paces conversions,
// drives CNV, launches both SPI masters together, waits for both to finish,
// latches the sample pair and reports overrun/timeout errors.
`timescale 1ns/1ps
module ad7903_acq_ctrl
  import ad7903_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int PERIOD_CYCLES   = 2000,
  parameter int CNV_HIGH_CYCLES = 4,
  parameter int CONV_CYCLES     = 110,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_single,
  input  logic                  i_clear,
  output logic                  o_cnv,
  output logic                  o_spi_start,
  input  logic [2:0]            i_spi_state_a,
  input  logic [2:0]            i_spi_state_b,
  input  logic [DATA_WIDTH-1:0] i_miso_data_a,
  input  logic [DATA_WIDTH-1:0] i_miso_data_b,
  output logic [DATA_WIDTH-1:0] o_data_a,
  output logic [DATA_WIDTH-1:0] o_data_b,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic                  o_timeout,
  output logic [31:0]           o_sample_cnt
);

  // One counter serves both the CNV/conversion phase and the SPI timeout.
  localparam int PH_MAX = (CONV_CYCLES > TIMEOUT_CYCLES) ? CONV_CYCLES : TIMEOUT_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] PH_CNV_END  = PH_W'(CNV_HIGH_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_CONV_END = PH_W'(CONV_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_TO_END   = PH_W'(TIMEOUT_CYCLES - 1);

  logic tick;

  ad7903_rate_tick #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_rate_tick (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .en_i  (i_enable),
    .tick_o(tick)
  );

  acq_state_t            state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic                  done_a_q, done_a_d, done_b_q, done_b_d;
  logic                  cnv_q, start_q, valid_q, busy_q, overrun_q, timeout_q;
  logic [DATA_WIDTH-1:0] data_a_q, data_b_q;
  logic [31:0]           cnt_q;
  logic                  to_event;
  logic                  ovr_event;
  logic                  done_a_now, done_b_now, both_active;

  // A channel counts as finished once its master has been seen idle in SPI_WAIT.
  assign done_a_now  = done_a_q | (i_spi_state_a == SPI_ST_IDLE);
  assign done_b_now  = done_b_q | (i_spi_state_b == SPI_ST_IDLE);
  assign both_active = (i_spi_state_a != SPI_ST_IDLE) && (i_spi_state_b != SPI_ST_IDLE);
  // A tick that arrives while an acquisition is in flight is dropped and flagged.
  assign ovr_event   = tick & busy_q;

  // Sequencer next-state, phase counter and per-channel completion tracking.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q + PH_W'(1);
    done_a_d = done_a_q;
    done_b_d = done_b_q;
    to_event = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d  = '0;
        done_a_d = 1'b0;
        done_b_d = 1'b0;
        if (tick || i_single) state_d = ST_CNV_HI;
      end
      ST_CNV_HI: begin
        if (phase_q == PH_CNV_END) state_d = ST_CONV_WAIT;
      end
      ST_CONV_WAIT: begin
        if (phase_q == PH_CONV_END) begin
          state_d = ST_SPI_START;
          phase_d = '0;
        end
      end
      ST_SPI_START: begin
        if (both_active) begin
          state_d = ST_SPI_WAIT;
        end else if (phase_q == PH_TO_END) begin
          state_d  = ST_IDLE;
          to_event = 1'b1;
        end
      end
      ST_SPI_WAIT: begin
        done_a_d = done_a_now;
        done_b_d = done_b_now;
        if (done_a_now && done_b_now) begin
          state_d = ST_LATCH;
        end else if (phase_q == PH_TO_END) begin
          state_d  = ST_IDLE;
          to_event = 1'b1;
        end
      end
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, counters and outputs decoded from the next state so every output is registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      cnv_q    <= 1'b0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      cnv_q    <= (state_d == ST_CNV_HI);
      start_q  <= (state_d == ST_SPI_START);
      valid_q  <= (state_d == ST_LATCH);
      busy_q   <= (state_d != ST_IDLE);
      if (state_d == ST_LATCH) begin
        data_a_q <= i_miso_data_a;
        data_b_q <= i_miso_data_b;
        cnt_q    <= cnt_q + 32'd1;
      end
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (ovr_event)    overrun_q <= 1'b1;
      else if (i_clear) overrun_q <= 1'b0;
      if (to_event)     timeout_q <= 1'b1;
      else if (i_clear) timeout_q <= 1'b0;
    end
  end

  assign o_cnv        = cnv_q;
  assign o_spi_start  = start_q;
  assign o_valid      = valid_q;
  assign o_busy       = busy_q;
  assign o_overrun    = overrun_q;
  assign o_timeout    = timeout_q;
  assign o_data_a     = data_a_q;
  assign o_data_b     = data_b_q;
  assign o_sample_cnt = cnt_q;

endmodule

// File: tb/tb_ad7903_acq_ctrl.sv
// Bench for ad7903_acq_ctrl with two behavioural SPI masters and
// expectations derived from the sequencer's timing rules.
`timescale 1ns/1ps
module tb_ad7903_acq_ctrl;

  localparam int DW     = 16;
  localparam int P      = 400;
  localparam int CNV_HI = 4;
  localparam int CONV   = 110;
  localparam int TOUT   = 1024;
  localparam int W_CNV_HI = 0, W_CNV_LO = 1, W_START = 2, W_VALID = 3, W_IDLE = 4, W_TOUT = 5;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, single = 1'b0, clr = 1'b0;
  logic cnv, start, valid, busy, ovr, tout;
  logic [2:0] st_a = 3'd0, st_b = 3'd0;
  logic [DW-1:0] miso_a = '0, miso_b = '0, d_a, d_b;
  logic [31:0] scnt;

  int errors = 0, checks = 0, cyc = 0, exp_cnt = 0;
  int valid_cnt = 0, cnv_rise_cnt = 0, t_done = 0;
  int len_a = 20, len_b = 20, cnt_a = 0, cnt_b = 0;
  logic [DW-1:0] word_a = '0, word_b = '0;
  logic stuck_a = 1'b0, mres = 1'b0, cnv_prev = 1'b0, both_idle_prev = 1'b1;

  ad7903_acq_ctrl #(
    .DATA_WIDTH(DW), .PERIOD_CYCLES(P), .CNV_HIGH_CYCLES(CNV_HI),
    .CONV_CYCLES(CONV), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_single(single), .i_clear(clr),
    .o_cnv(cnv), .o_spi_start(start),
    .i_spi_state_a(st_a), .i_spi_state_b(st_b),
    .i_miso_data_a(miso_a), .i_miso_data_b(miso_b),
    .o_data_a(d_a), .o_data_b(d_b), .o_valid(valid), .o_busy(busy),
    .o_overrun(ovr), .o_timeout(tout), .o_sample_cnt(scnt)
  );

  always #2.5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SPI master A: idle(0) -> busy(1,2...) for len_a cycles -> done(4) -> idle.
  always @(posedge clk) begin
    if (mres) st_a <= 3'd0;
    else case (st_a)
      3'd0: if (start) begin st_a <= 3'd1; cnt_a <= 0; end
      3'd4: st_a <= 3'd0;
      default: if (stuck_a) st_a <= 3'd2;
               else if (cnt_a >= len_a - 1) begin st_a <= 3'd4; miso_a <= word_a; end
               else begin st_a <= 3'd2; cnt_a <= cnt_a + 1; end
    endcase
  end

  // Behavioural SPI master B.
  always @(posedge clk) begin
    case (st_b)
      3'd0: if (start) begin st_b <= 3'd1; cnt_b <= 0; end
      3'd4: st_b <= 3'd0;
      default: if (cnt_b >= len_b - 1) begin st_b <= 3'd4; miso_b <= word_b; end
               else begin st_b <= 3'd2; cnt_b <= cnt_b + 1; end
    endcase
  end

  // Event monitor: valid pulses, CNV rises, and the cycle both masters came back idle.
  always @(negedge clk) begin
    cnv_prev <= cnv;
    if (valid) valid_cnt <= valid_cnt + 1;
    if (cnv && !cnv_prev) cnv_rise_cnt <= cnv_rise_cnt + 1;
    both_idle_prev <= (st_a == 3'd0 && st_b == 3'd0);
    if (st_a == 3'd0 && st_b == 3'd0 && !both_idle_prev) t_done <= cyc;
  end

  task automatic wait_sig(input int sel, input int limit, output int t, output bit ok);
    logic hit;
    ok = 1'b0; t = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      case (sel)
        W_CNV_HI: hit = cnv;
        W_CNV_LO: hit = !cnv;
        W_START:  hit = start;
        W_VALID:  hit = valid;
        W_IDLE:   hit = !busy;
        default:  hit = tout;
      endcase
      if (hit === 1'b1) begin ok = 1'b1; t = cyc; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_event_%0d got=none within %0d cycles exp=event", sel, limit);
    end
  endtask

  task automatic pulse_single();
    @(posedge clk); #1 single = 1'b1;
    @(posedge clk); #1 single = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (cnv !== 1'b0)   begin errors++; $display("FAIL reset_cnv got=%b exp=0", cnv); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", start); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ovr !== 1'b0)   begin errors++; $display("FAIL reset_overrun got=%b exp=0", ovr); end
    checks++; if (tout !== 1'b0)  begin errors++; $display("FAIL reset_timeout got=%b exp=0", tout); end
    checks++; if (d_a !== '0 || d_b !== '0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0/0", d_a, d_b); end
    checks++; if (scnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", scnt); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_periodic();
    int t_en, t_c, t_prev, t_f, t_s, t_v, dt, exp_dt; bit ok;
    len_a = $urandom_range(10, 40); len_b = $urandom_range(10, 40);
    t_prev = 0;
    @(posedge clk); #1 en = 1'b1; t_en = cyc;
    for (int k = 0; k < 3; k++) begin
      word_a = (k == 0) ? 16'h1234 : 16'($urandom);
      word_b = (k == 0) ? 16'hBEEF : 16'($urandom);
      wait_sig(W_CNV_HI, P + 20, t_c, ok);
      dt = (k == 0) ? (t_c - t_en) : (t_c - t_prev);
      exp_dt = (k == 0) ? P + 1 : P;
      checks++; if (dt !== exp_dt) begin errors++; $display("FAIL periodic_cnv_spacing k=%0d got=%0d exp=%0d", k, dt, exp_dt); end
      wait_sig(W_CNV_LO, 20, t_f, ok);
      checks++; if (t_f - t_c !== CNV_HI) begin errors++; $display("FAIL periodic_cnv_width got=%0d exp=%0d", t_f - t_c, CNV_HI); end
      wait_sig(W_START, CONV + 20, t_s, ok);
      checks++; if (t_s - t_c !== CONV) begin errors++; $display("FAIL periodic_cnv_to_start got=%0d exp=%0d", t_s - t_c, CONV); end
      wait_sig(W_VALID, 200, t_v, ok);
      exp_cnt++;
      checks++; if (d_a !== word_a || d_b !== word_b) begin errors++; $display("FAIL periodic_data got=%h/%h exp=%h/%h", d_a, d_b, word_a, word_b); end
      checks++; if (scnt !== 32'(exp_cnt)) begin errors++; $display("FAIL periodic_cnt got=%0d exp=%0d", scnt, exp_cnt); end
      checks++; if (t_v !== t_done + 1) begin errors++; $display("FAIL periodic_valid_latency got=%0d exp=%0d", t_v - t_done, 1); end
      @(negedge clk);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL periodic_valid_width got=%b exp=0", valid); end
      t_prev = t_c;
    end
    @(posedge clk); #1 en = 1'b0;
    wait_sig(W_IDLE, 100, t_f, ok);
  endtask

  task automatic test_skew();
    int t_v, v0; bit ok, found;
    len_a = $urandom_range(8, 30); len_b = len_a + 7;
    word_a = 16'($urandom); word_b = 16'($urandom);
    @(negedge clk); #1 v0 = valid_cnt;
    pulse_single();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (st_a != 3'd0 && st_b != 3'd0) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL skew_masters_started got=no exp=yes"); end
    @(negedge clk);
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL skew_start_drop got=%b exp=0", start); end
    wait_sig(W_VALID, 200, t_v, ok);
    exp_cnt++;
    checks++; if (t_v !== t_done + 1) begin errors++; $display("FAIL skew_valid_latency got=%0d exp=%0d", t_v - t_done, 1); end
    checks++; if (d_a !== word_a || d_b !== word_b) begin errors++; $display("FAIL skew_data got=%h/%h exp=%h/%h", d_a, d_b, word_a, word_b); end
    repeat (30) @(negedge clk);
    #1;
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL skew_valid_count got=%0d exp=1", valid_cnt - v0); end
  endtask

  task automatic test_single();
    int t_v, v0, c0; bit ok;
    len_a = $urandom_range(10, 40); len_b = $urandom_range(10, 40);
    word_a = 16'($urandom); word_b = 16'($urandom);
    @(negedge clk); #1 v0 = valid_cnt; c0 = cnv_rise_cnt;
    pulse_single();
    repeat (15) @(posedge clk);
    pulse_single();
    wait_sig(W_VALID, 300, t_v, ok);
    exp_cnt++;
    checks++; if (d_a !== word_a || d_b !== word_b) begin errors++; $display("FAIL single_data got=%h/%h exp=%h/%h", d_a, d_b, word_a, word_b); end
    checks++; if (scnt !== 32'(exp_cnt)) begin errors++; $display("FAIL single_cnt got=%0d exp=%0d", scnt, exp_cnt); end
    repeat (300) @(negedge clk);
    #1;
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL single_valid_count got=%0d exp=1", valid_cnt - v0); end
    checks++; if (cnv_rise_cnt - c0 !== 1) begin errors++; $display("FAIL single_cnv_count got=%0d exp=1", cnv_rise_cnt - c0); end
  endtask

  task automatic test_overrun();
    int t0, t1, t_i, v0, v1; bit ok;
    len_a = 500; len_b = 500 + $urandom_range(0, 20);
    word_a = 16'($urandom); word_b = 16'($urandom);
    @(posedge clk); #1 en = 1'b1;
    wait_sig(W_CNV_HI, P + 20, t0, ok);
    #1 v0 = valid_cnt;
    while (cyc < t0 + P - 1) @(negedge clk);
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL overrun_early got=%b exp=0", ovr); end
    @(negedge clk);
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b exp=1", ovr); end
    wait_sig(W_CNV_HI, P + 50, t1, ok);
    #1 v1 = valid_cnt;
    checks++; if (t1 - t0 !== 2 * P) begin errors++; $display("FAIL overrun_tick_dropped got=%0d exp=%0d", t1 - t0, 2 * P); end
    checks++; if (v1 - v0 !== 1) begin errors++; $display("FAIL overrun_valid_count got=%0d exp=1", v1 - v0); end
    do begin @(posedge clk); #1; end while (cyc < t1 + 10);
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL overrun_clear got=%b exp=0", ovr); end
    do begin @(posedge clk); #1; end while (cyc < t1 - 1 + P);
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL overrun_error_beats_clear got=%b exp=1", ovr); end
    @(posedge clk); #1 en = 1'b0;
    wait_sig(W_IDLE, 800, t_i, ok);
    exp_cnt += 2;
    checks++; if (scnt !== 32'(exp_cnt)) begin errors++; $display("FAIL overrun_cnt got=%0d exp=%0d", scnt, exp_cnt); end
    checks++; if (d_a !== word_a || d_b !== word_b) begin errors++; $display("FAIL overrun_data got=%h/%h exp=%h/%h", d_a, d_b, word_a, word_b); end
    pulse_clear();
    @(negedge clk);
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL overrun_final_clear got=%b exp=0", ovr); end
  endtask

  task automatic test_timeout();
    int t_s, t_to, v0; bit ok;
    logic [DW-1:0] prev_a, prev_b;
    len_b = $urandom_range(10, 40);
    word_a = ~d_a; word_b = ~d_b;
    @(negedge clk); #1 prev_a = d_a; prev_b = d_b; v0 = valid_cnt;
    stuck_a = 1'b1;
    pulse_single();
    wait_sig(W_START, 200, t_s, ok);
    wait_sig(W_TOUT, TOUT + 50, t_to, ok);
    checks++; if (t_to - t_s !== TOUT) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", t_to - t_s, TOUT); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_to_idle got=%b exp=0", busy); end
    checks++; if (d_a !== prev_a || d_b !== prev_b) begin errors++; $display("FAIL timeout_data_held got=%h/%h exp=%h/%h", d_a, d_b, prev_a, prev_b); end
    #1;
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL timeout_no_valid got=%0d exp=%0d", valid_cnt - v0, 0); end
    stuck_a = 1'b0;
    @(posedge clk); #1 mres = 1'b1;
    @(posedge clk); #1 mres = 1'b0;
    pulse_clear();
    @(negedge clk);
    checks++; if (tout !== 1'b0) begin errors++; $display("FAIL timeout_clear got=%b exp=0", tout); end
  endtask

  task automatic test_reset_mid();
    int t_c, t_v; bit ok;
    len_a = $urandom_range(10, 40); len_b = $urandom_range(10, 40);
    word_a = 16'($urandom); word_b = 16'($urandom);
    pulse_single();
    wait_sig(W_CNV_HI, 20, t_c, ok);
    repeat (30) @(negedge clk);
    #1 rst = 1'b1;
    #0.5;
    checks++; if (cnv !== 1'b0 || start !== 1'b0) begin errors++; $display("FAIL rstmid_cnv_start got=%b/%b exp=0/0", cnv, start); end
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL rstmid_busy_valid got=%b/%b exp=0/0", busy, valid); end
    checks++; if (scnt !== 32'd0) begin errors++; $display("FAIL rstmid_cnt got=%0d exp=0", scnt); end
    checks++; if (d_a !== '0 || d_b !== '0) begin errors++; $display("FAIL rstmid_data got=%h/%h exp=0/0", d_a, d_b); end
    @(posedge clk); #1 rst = 1'b0;
    exp_cnt = 0;
    word_a = 16'($urandom); word_b = 16'($urandom);
    pulse_single();
    wait_sig(W_VALID, 300, t_v, ok);
    exp_cnt++;
    checks++; if (scnt !== 32'(exp_cnt)) begin errors++; $display("FAIL rstmid_cnt_restart got=%0d exp=%0d", scnt, exp_cnt); end
    checks++; if (d_a !== word_a || d_b !== word_b) begin errors++; $display("FAIL rstmid_data_after got=%h/%h exp=%h/%h", d_a, d_b, word_a, word_b); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=still running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_periodic();
    test_skew();
    test_single();
    test_overrun();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
